uart_rx_fifo: RTL

UART receiver with a small receive FIFO, placed upstream of the CPU's memory-mapped IO page; it finally gives the SOC's RXD pin a consumer.
- Deserialises 8N1 frames from RXD at the same bit rate as the existing transmit emitter, and buffers received bytes.
- The SOC pops bytes through an IO data-register read and exposes `rx_valid`, `level` and the error flags through an IO status word.

---
 rtl/uart_rx_fifo.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a small show-ahead FIFO with sticky overrun/framing flags.
// The baud counter is loaded on the synchronised start edge, so all samples land mid-bit.
module uart_rx_fifo #(
  parameter int CLK_DIVIDER = 8,
  parameter int FIFO_AW     = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               rxd,
  input  logic               rd_en,
  output logic [7:0]         rd_data,
  output logic               rx_valid,
  output logic [FIFO_AW:0]   level,
  output logic               overrun,
  output logic               frame_err,
  input  logic               clr_err
);

  localparam int CW    = $clog2(CLK_DIVIDER);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [CW-1:0]    HALF_RELOAD = CW'(CLK_DIVIDER / 2 - 1);
  localparam logic [CW-1:0]    BIT_RELOAD  = CW'(CLK_DIVIDER - 1);
  localparam logic [FIFO_AW:0] FULL_LEVEL  = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t              state, state_next;
  logic [CW-1:0]       cnt, cnt_next;
  logic [2:0]          bit_idx, idx_next;
  logic [7:0]          shreg, shreg_next;
  logic                rxd_m, rxd_s, rxd_d;
  logic                fall;
  logic                push, pop, full, empty;
  logic                set_ovr, set_fe;
  logic [FIFO_AW:0]    wr_ptr, rd_ptr;
  logic [7:0]          mem [DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_d <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      rxd_d <= rxd_s;
    end
  end

  assign fall  = rxd_d & ~rxd_s;
  assign level = wr_ptr - rd_ptr;
  assign empty = (level == '0);
  assign full  = (level == FULL_LEVEL);
  assign pop   = rd_en & ~empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= idx_next;
      shreg   <= shreg_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = bit_idx;
    shreg_next = shreg;
    push       = 1'b0;
    set_ovr    = 1'b0;
    set_fe     = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          cnt_next   = HALF_RELOAD;
          state_next = START;
        end
      end
      START: begin
        if (cnt != '0) begin
          cnt_next = cnt - 1'b1;
        end else if (rxd_s) begin
          state_next = IDLE;
        end else begin
          cnt_next   = BIT_RELOAD;
          idx_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (cnt != '0) begin
          cnt_next = cnt - 1'b1;
        end else begin
          shreg_next = {rxd_s, shreg[7:1]};
          cnt_next   = BIT_RELOAD;
          if (bit_idx == 3'd7) state_next = STOP;
          else                 idx_next   = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (cnt != '0) begin
          cnt_next = cnt - 1'b1;
        end else if (rxd_s) begin
          // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
          if (!full || pop) push    = 1'b1;
          else              set_ovr = 1'b1;
          state_next = IDLE;
        end else begin
          set_fe     = 1'b1;
          state_next = BREAK;
        end
      end
      BREAK: begin
        if (rxd_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[FIFO_AW-1:0]] <= shreg;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign rx_valid = ~empty;
  assign rd_data  = rx_valid ? mem[rd_ptr[FIFO_AW-1:0]] : 8'h00;

  // Set wins over a coincident clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (set_ovr)      overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
      if (set_fe)       frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

endmodule
